// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detector: tracks in-flight mul/div destinations and stalls
// ID on load-use, busy-register RAW/WAW and mul/div structural hazards.
module hazard_scoreboard #(
    parameter int unsigned MAX_PENDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_id,
    input  logic [4:0]  id_rs2_id,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd_id,
    input  logic        id_reg_write,
    input  logic        id_is_muldiv,
    input  logic [4:0]  ex_rd_id,
    input  logic        ex_reg_write,
    input  logic        ex_is_load,
    input  logic        md_done,
    input  logic [4:0]  md_rd_id,
    input  logic        flush,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic [31:0] busy_vec,
    output logic [2:0]  pending_cnt,
    output logic [1:0]  stall_reason,
    output logic [31:0] stall_cycles
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned NREGS  = 32;
    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_LOAD = 2'b01;
    localparam logic [1:0] R_BUSY = 2'b10;
    localparam logic [1:0] R_FULL = 2'b11;

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [1:0]       reason_q, reason_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic active, load_use, raw, waw, full, stall, issue;

    // Hazard terms, all gated off by an empty or flushed ID slot
    always_comb begin
        active   = id_valid & ~flush;
        load_use = active & ex_is_load & ex_reg_write & (ex_rd_id != 5'd0) &
                   ((id_uses_rs1 & (ex_rd_id == id_rs1_id)) |
                    (id_uses_rs2 & (ex_rd_id == id_rs2_id)));
        raw      = active & ((id_uses_rs1 & busy_q[id_rs1_id]) |
                             (id_uses_rs2 & busy_q[id_rs2_id]));
        waw      = active & id_reg_write & busy_q[id_rd_id];
        full     = active & id_is_muldiv & (pend_q == CNT_W'(MAX_PENDING));
        stall    = load_use | raw | waw | full;
        issue    = active & id_is_muldiv & ~stall;
    end

    assign stall_id  = stall;
    assign bubble_ex = stall;

    // Next-state: reason FSM, scoreboard, in-flight counter, stall counter
    always_comb begin
        reason_d    = R_NONE;
        busy_d      = busy_q;
        pend_d      = pend_q;
        stall_cnt_d = stall_cnt_q;

        if (load_use)        reason_d = R_LOAD;
        else if (raw | waw)  reason_d = R_BUSY;
        else if (full)       reason_d = R_FULL;

        // Clear before set so a same-cycle set on the same register wins
        if (md_done)
            busy_d[md_rd_id] = 1'b0;
        if (issue && id_reg_write && (id_rd_id != 5'd0))
            busy_d[id_rd_id] = 1'b1;
        busy_d[0] = 1'b0;

        case ({issue, md_done})
            2'b10:   pend_d = pend_q + CNT_W'(1);
            2'b01:   if (pend_q != '0) pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
        endcase

        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reason_q    <= R_NONE;
            busy_q      <= '0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            reason_q    <= reason_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_vec     = busy_q;
    assign pending_cnt  = pend_q;
    assign stall_reason = reason_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, mul/div RAW, structural,
// WAW/x0, flush, simultaneous issue/complete and asynchronous reset.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_muldiv;
    logic [4:0]  id_rs1_id, id_rs2_id, id_rd_id, ex_rd_id, md_rd_id;
    logic        ex_reg_write, ex_is_load, md_done, flush;
    logic        stall_id, bubble_ex;
    logic [31:0] busy_vec, stall_cycles;
    logic [2:0]  pending_cnt;
    logic [1:0]  stall_reason;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int proto_err = 0;

    hazard_scoreboard #(.MAX_PENDING(2)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_id(id_rd_id), .id_reg_write(id_reg_write), .id_is_muldiv(id_is_muldiv),
        .ex_rd_id(ex_rd_id), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .md_done(md_done), .md_rd_id(md_rd_id), .flush(flush),
        .stall_id(stall_id), .bubble_ex(bubble_ex), .busy_vec(busy_vec),
        .pending_cnt(pending_cnt), .stall_reason(stall_reason), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Completion with nothing in flight is a protocol error on the bench side
    always @(posedge clk)
        if (reset_n && md_done && pending_cnt == 3'd0) proto_err++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_reg_write = 0; id_is_muldiv = 0;
        id_rs1_id = 0; id_rs2_id = 0; id_rd_id = 0;
        ex_rd_id = 0; ex_reg_write = 0; ex_is_load = 0;
        md_done = 0; md_rd_id = 0; flush = 0;
    endtask

    task automatic set_id(input logic md, input logic [4:0] rd, input logic wr,
                          input logic u1, input logic [4:0] r1,
                          input logic u2, input logic [4:0] r2);
        id_valid = 1; id_is_muldiv = md; id_rd_id = rd; id_reg_write = wr;
        id_uses_rs1 = u1; id_rs1_id = r1; id_uses_rs2 = u2; id_rs2_id = r2;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        #12;
        checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
        checks++; if (stall_reason !== 2'b00) begin failures++; $display("FAIL reset_reason got=%b exp=00", stall_reason); end
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
        checks++; if (stall_id !== 1'b0 || bubble_ex !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b%b exp=00", stall_id, bubble_ex); end
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_is_load = 1; ex_reg_write = 1; ex_rd_id = 5;
        set_id(0, 6, 1, 1, 5, 1, 1);
        #1;
        checks++; if (stall_id !== 1'b1 || bubble_ex !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%b%b exp=11", stall_id, bubble_ex); end
        exp_stall++;
        tick();
        checks++; if (stall_reason !== 2'b01) begin failures++; $display("FAIL load_use_reason got=%b exp=01", stall_reason); end
        ex_is_load = 0; ex_reg_write = 0; ex_rd_id = 0;
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b exp=0", stall_id); end
        tick();
        checks++; if (stall_reason !== 2'b00) begin failures++; $display("FAIL load_use_reason_clr got=%b exp=00", stall_reason); end
    endtask

    task automatic test_muldiv_raw();
        idle();
        set_id(1, 7, 1, 1, 1, 1, 2);
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL div_issue_stall got=%b exp=0", stall_id); end
        tick();
        checks++; if (busy_vec !== 32'h80 || pending_cnt !== 3'd1) begin failures++; $display("FAIL div_issue got=%h/%0d exp=80/1", busy_vec, pending_cnt); end
        set_id(0, 8, 1, 1, 7, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            md_done = (c == 10); md_rd_id = (c == 10) ? 5'd7 : 5'd0;
            #1;
            checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL raw_stall_c%0d got=%b exp=1", c, stall_id); end
            exp_stall++;
            tick();
        end
        md_done = 0; md_rd_id = 0;
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL raw_release got=%b exp=0", stall_id); end
        checks++; if (busy_vec !== 32'h0 || pending_cnt !== 3'd0) begin failures++; $display("FAIL raw_clear got=%h/%0d exp=0/0", busy_vec, pending_cnt); end
        checks++; if (stall_reason !== 2'b10) begin failures++; $display("FAIL raw_reason got=%b exp=10", stall_reason); end
        checks++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL raw_stall_cycles got=%0d exp=%0d", stall_cycles, exp_stall); end
        tick();
    endtask

    task automatic test_structural();
        idle();
        set_id(1, 1, 1, 0, 0, 0, 0); tick();
        set_id(1, 2, 1, 0, 0, 0, 0); tick();
        checks++; if (busy_vec !== 32'h6 || pending_cnt !== 3'd2) begin failures++; $display("FAIL struct_fill got=%h/%0d exp=6/2", busy_vec, pending_cnt); end
        set_id(1, 3, 1, 0, 0, 0, 0);
        #1;
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL struct_stall got=%b exp=1", stall_id); end
        exp_stall++;
        tick();
        checks++; if (stall_reason !== 2'b11 || pending_cnt !== 3'd2) begin failures++; $display("FAIL struct_reason got=%b/%0d exp=11/2", stall_reason, pending_cnt); end
        md_done = 1; md_rd_id = 1;
        #1;
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL struct_done_cycle got=%b exp=1", stall_id); end
        exp_stall++;
        tick();
        md_done = 0; md_rd_id = 0;
        #1;
        checks++; if (stall_id !== 1'b0 || pending_cnt !== 3'd1 || busy_vec !== 32'h4) begin failures++; $display("FAIL struct_free got=%b/%0d/%h exp=0/1/4", stall_id, pending_cnt, busy_vec); end
        tick();
        checks++; if (pending_cnt !== 3'd2 || busy_vec !== 32'hC) begin failures++; $display("FAIL struct_third got=%0d/%h exp=2/c", pending_cnt, busy_vec); end
        idle();
        md_done = 1; md_rd_id = 2; tick();
        md_rd_id = 3; tick();
        md_done = 0; md_rd_id = 0;
        checks++; if (pending_cnt !== 3'd0 || busy_vec !== 32'h0) begin failures++; $display("FAIL struct_drain got=%0d/%h exp=0/0", pending_cnt, busy_vec); end
    endtask

    task automatic test_waw_x0();
        idle();
        set_id(1, 4, 1, 0, 0, 0, 0); tick();
        set_id(0, 4, 1, 1, 1, 0, 0);
        #1;
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall_id); end
        exp_stall++;
        tick();
        checks++; if (stall_reason !== 2'b10) begin failures++; $display("FAIL waw_reason got=%b exp=10", stall_reason); end
        set_id(1, 0, 1, 1, 1, 1, 2);
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", stall_id); end
        tick();
        checks++; if (busy_vec !== 32'h10 || pending_cnt !== 3'd2) begin failures++; $display("FAIL x0_issue got=%h/%0d exp=10/2", busy_vec, pending_cnt); end
    endtask

    task automatic test_flush_simul();
        idle();
        set_id(1, 9, 1, 1, 4, 0, 0);
        flush = 1;
        #1;
        checks++; if (stall_id !== 1'b0 || bubble_ex !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b%b exp=00", stall_id, bubble_ex); end
        tick();
        checks++; if (stall_reason !== 2'b00 || pending_cnt !== 3'd2 || busy_vec !== 32'h10) begin failures++; $display("FAIL flush_state got=%b/%0d/%h exp=00/2/10", stall_reason, pending_cnt, busy_vec); end
        idle();
        md_done = 1; md_rd_id = 0; tick();
        set_id(1, 5, 1, 1, 1, 0, 0);
        md_done = 1; md_rd_id = 5;
        tick();
        idle();
        checks++; if (busy_vec !== 32'h30 || pending_cnt !== 3'd1) begin failures++; $display("FAIL simul got=%h/%0d exp=30/1", busy_vec, pending_cnt); end
    endtask

    task automatic test_reset_mid();
        idle();
        md_done = 1; md_rd_id = 5; tick();
        md_done = 0; md_rd_id = 0;
        set_id(1, 7, 1, 0, 0, 0, 0); tick();
        set_id(0, 8, 1, 1, 7, 0, 0);
        for (int guard = 0; guard < 100 && exp_stall < 37; guard++) begin
            exp_stall++;
            tick();
        end
        checks++; if (busy_vec !== 32'h90 || stall_cycles !== 32'd37) begin failures++; $display("FAIL pre_reset got=%h/%0d exp=90/37", busy_vec, stall_cycles); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (busy_vec !== 32'h0 || pending_cnt !== 3'd0 || stall_cycles !== 32'd0) begin failures++; $display("FAIL async_reset got=%h/%0d/%0d exp=0/0/0", busy_vec, pending_cnt, stall_cycles); end
        idle();
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv_raw();
        test_structural();
        test_waw_x0();
        test_flush_simul();
        test_reset_mid();
        checks++; if (proto_err !== 0) begin failures++; $display("FAIL md_done_underflow got=%0d exp=0", proto_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
